ysyx_2022040010_mul_seq: RTL and testbench
==========================================

YSYX_2022040010_MUL_SEQ -- requirements
Module: ysyx_2022040010_mul_seq

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operation request.
REQ-004 SHALL have port in_ready, output, 1 bit: request accepted when in_valid & in_ready at a clock edge.
REQ-005 SHALL have port in_op_w, input, 1 bit: 1 = MULW (32-bit), 0 = MUL (64-bit).
REQ-006 SHALL have port in_src1, input, 64 bits: multiplicand.
REQ-007 SHALL have port in_src2, input, 64 bits: multiplier.
REQ-008 SHALL have port flush, input, 1 bit: abort any operation in progress.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: result consumed when out_valid & out_ready at a clock edge.
REQ-011 SHALL have port out_result, output, 64 bits: product.
REQ-012 SHALL have ports add_a (64, out), add_b (64, out), add_cin (1, out), add_32 (1, out), add_s (64, in), add_c (1, in), connecting to the shared combinational 64-bit ripple adder.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL, on accept in IDLE: latch acc = 0, mc = in_src1, mp = in_src2, op_w = in_op_w, cnt = 0; go to BUSY.
REQ-016 SHALL, in BUSY, drive add_a = acc, add_b = mp[0] ? mc : 0, add_cin = 0, add_32 = op_w.
REQ-017 SHALL, each BUSY edge: acc <= add_s; mc <= mc << 1; mp <= mp >> 1 (logical); cnt <= cnt + 1.
REQ-018 SHALL leave BUSY for DONE on the edge where cnt reaches N-1, N = 64 (MUL) or 32 (MULW); latch out_result = add_s on that edge.
REQ-019 SHALL therefore assert out_valid exactly N cycles after the accepting edge; latency fixed, independent of operand values (no early-out on zero operands).
REQ-020 SHALL produce MUL result = low 64 bits of src1*src2 (mod 2^64), identical for signed/unsigned.
REQ-021 SHALL produce MULW result = sign-extension of bit 31 of low 32 bits of src1[31:0]*src2[31:0]; src upper 32 bits ignored.
REQ-022 SHALL ignore add_c (carry-out discarded, wrap mod 2^64 / 2^32).
REQ-023 SHALL hold out_valid and out_result stable in DONE until out_ready; on out_valid & out_ready go to IDLE.
REQ-024 SHALL NOT accept a new request in the cycle the result is consumed (in_ready low in DONE); next accept earliest one cycle later.
REQ-025 SHALL, on flush = 1 at an edge in any state, go to IDLE, discard the operation and any pending result, and not accept in_valid that edge (flush wins over accept).
REQ-026 SHALL drive add_a, add_b, add_cin to 0 and add_32 to 0 outside BUSY.
REQ-027 SHALL ignore in_src1/in_src2/in_op_w changes after accept.

Reset
REQ-028 SHALL, while reset = 1, asynchronously force state = IDLE, acc/mc/mp/cnt/op_w = 0, out_result = 0, out_valid = 0, in_ready = 1 (reset deasserted), adder drive outputs 0.
REQ-029 SHALL abort any in-flight operation on reset mid-BUSY or mid-DONE; no result emitted afterwards.
REQ-030 SHALL accept a request on the first clock edge after reset deassertion.

Verification
REQ-031 SHALL cover: MUL src1=3, src2=5, out_ready=1 -> out_valid after 64 cycles, out_result = 0x000000000000000F.
REQ-032 SHALL cover: MUL src1=0xFFFFFFFFFFFFFFFF, src2=0xFFFFFFFFFFFFFFFF -> out_result = 0x0000000000000001 at cycle 64.
REQ-033 SHALL cover: MULW src1=0xDEADBEEF7FFFFFFF, src2=0x0000000000000002 -> out_valid at cycle 32, out_result = 0xFFFFFFFFFFFFFFFE.
REQ-034 SHALL cover: MUL 7*6 with out_ready=0 for 10 cycles after out_valid -> out_valid and out_result = 0x2A held stable, in_ready = 0 throughout, IDLE one edge after out_ready=1.
REQ-035 SHALL cover: flush at cycle 20 of MUL, simultaneous in_valid -> IDLE next cycle, out_valid never asserts, request not accepted; new MUL 2*2 then yields 4 at cycle 64.
REQ-036 SHALL cover: reset asserted asynchronously mid-BUSY (between edges) -> out_valid = 0, in_ready = 1 immediately; no result after reset release.

Source files
------------

// File: rtl/ysyx_2022040010_mul_seq.sv
// Sequential shift-and-add multiplier (RV64 MUL / MULW), one partial product per cycle.
// The additions use an external shared 64-bit ripple adder through the add_* ports.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     request handshake; in_op_w selects MULW (1) or MUL (0)
//   in_src1, in_src2      multiplicand / multiplier, captured on accept
//   flush                 aborts any operation or pending result
//   out_valid/out_ready   result handshake; out_result holds the product
//   add_a, add_b, add_cin, add_32   operands / mode driven to the shared adder
//   add_s, add_c          sum and carry-out returned by the shared adder
module ysyx_2022040010_mul_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op_w,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  output logic        add_cin,
  output logic        add_32,
  input  logic [63:0] add_s,
  input  logic        add_c
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mc_q, mc_d;
  logic [63:0] mp_q, mp_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_w_q, op_w_d;
  logic [63:0] result_q, result_d;
  logic [5:0]  cnt_last;

  // Carry-out is never needed: products wrap modulo 2^64 (or 2^32 for MULW).
  logic unused_add_c;
  assign unused_add_c = add_c;

  assign cnt_last = op_w_q ? 6'd31 : 6'd63;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      cnt_q    <= '0;
      op_w_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      cnt_q    <= cnt_d;
      op_w_q   <= op_w_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    cnt_d    = cnt_q;
    op_w_d   = op_w_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StBusy;
          acc_d   = '0;
          mc_d    = in_src1;
          mp_d    = in_src2;
          op_w_d  = in_op_w;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        acc_d = add_s;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == cnt_last) begin
          state_d = StDone;
          // Sign-extend locally so the result does not depend on how the
          // adder fills the upper half in 32-bit mode.
          result_d = op_w_q ? {{32{add_s[31]}}, add_s[31:0]} : add_s;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush dominates everything, including a same-cycle accept.
    if (flush) state_d = StIdle;
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StDone);
    out_result = result_q;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    add_32     = 1'b0;
    if (state_q == StBusy) begin
      add_a  = acc_q;
      add_b  = mp_q[0] ? mc_q : '0;
      add_32 = op_w_q;
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_mul_seq.sv
module tb_ysyx_2022040010_mul_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_op_w;
  logic [63:0] in_src1, in_src2;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic [63:0] add_a, add_b, add_s;
  logic        add_cin, add_32, add_c;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rand_rdy = 1'b0;
  logic prev_valid = 1'b0;

  logic [63:0] exp_q[$];
  int          acc_q[$];
  int          n_q[$];

  ysyx_2022040010_mul_seq dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op_w   (in_op_w),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_32    (add_32),
    .add_s     (add_s),
    .add_c     (add_c)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Shared adder model; 32-bit mode sign-extends its 32-bit sum.
  logic [64:0] sum65;
  logic [31:0] sum32;
  always_comb begin
    sum65 = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};
    sum32 = add_a[31:0] + add_b[31:0] + {31'd0, add_cin};
    add_s = add_32 ? {{32{sum32[31]}}, sum32} : sum65[63:0];
    add_c = sum65[64];
  end

  function automatic logic [63:0] model(input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] pw;
    if (w) begin
      pw = a[31:0] * b[31:0];
      return {{32{pw[31]}}, pw};
    end
    return a * b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: checks latency on the rising edge of out_valid, result while held, pops on handshake.
  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!prev_valid) chk("latency", 64'(cyc - acc_q[0]), 64'(n_q[0]));
          chk("result", out_result, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            void'(n_q.pop_front());
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Drive a request; the scoreboard entry is pushed when acceptance is certain.
  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] b);
    int guard = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_op_w  = w;
    in_src1  = a;
    in_src2  = b;
    while (!in_ready && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(w, a, b));
    acc_q.push_back(cyc + 1);
    n_q.push_back(w ? 32 : 64);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    // Operands changing after accept must not matter.
    in_src1 = {$urandom, $urandom};
    in_src2 = {$urandom, $urandom};
    in_op_w = ~w;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
  endtask

  task automatic wait_valid();
    int guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!out_valid) chk("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  logic [63:0] ra, rb;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_op_w = 1'b0;
    in_src1 = '0;
    in_src2 = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_add_a", add_a, 64'd0);
    chk("rst_add_b", add_b, 64'd0);
    chk("rst_add_ctl", {62'd0, add_cin, add_32}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Accepted on the first edge after reset release.
    issue(1'b0, 64'd3, 64'd5);
    drain();
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    issue(1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2);
    drain();
    chk("idle_add_a", add_a, 64'd0);

    // Back-pressure: result held for 10 cycles.
    out_ready = 1'b0;
    issue(1'b0, 64'd7, 64'd6);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_result", out_result, 64'h2A);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("post_consume_idle", 64'(in_ready), 64'd1);
    drain();

    // Flush mid-BUSY with a competing request.
    issue(1'b0, 64'd9, 64'd9);
    repeat (19) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    in_valid = 1'b1;
    in_src1 = 64'd11;
    in_src2 = 64'd13;
    exp_q.delete();
    acc_q.delete();
    n_q.delete();
    @(posedge clock);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle", 64'(in_ready), 64'd1);
    chk("flush_no_valid", 64'(out_valid), 64'd0);
    repeat (70) @(negedge clock);
    issue(1'b0, 64'd2, 64'd2);
    drain();

    // Asynchronous reset between edges mid-BUSY.
    issue(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_add_a", add_a, 64'd0);
    exp_q.delete();
    acc_q.delete();
    n_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (70) @(negedge clock);
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Randomized traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 7 == 3) rb = '0;
      if (i % 7 == 5) ra = '1;
      issue(1'($urandom_range(0, 1)), ra, rb);
    end
    drain();
    rand_rdy = 1'b0;
    #1 out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
